// File: rtl/ddrvfifo_wr_packer.sv
// Packs 32-bit producer words into 128-bit bursts for the virtual-FIFO core.
// Partial bursts are emitted on FLUSH or after FLUSH_TIMEOUT idle cycles.
module ddrvfifo_wr_packer #(
    parameter int ADDR_WIDTH    = 24,
    parameter int FLUSH_TIMEOUT = 255
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic [31:0]           DATA_IN,
    input  logic                  WRITE,
    output logic                  FULL,
    input  logic                  FLUSH,
    output logic [127:0]          BURST_DATA,
    output logic [3:0]            BURST_MASK,
    output logic [ADDR_WIDTH-1:0] BURST_ADDR,
    output logic                  BURST_VALID,
    input  logic                  BURST_READY,
    output logic [7:0]            LOST_CNT,
    output logic [31:0]           BURST_CNT,
    output logic                  DBG_STATE
);

    // Handshake: a burst transfers on any rising edge where BURST_VALID and
    // BURST_READY are both 1; BURST_READY is ignored while BURST_VALID is 0.
    typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [7:0] TMO_LIMIT = 8'(FLUSH_TIMEOUT);

    state_t     state;
    logic [2:0] slot;
    logic [7:0] tmo;

    logic       accept;
    logic [2:0] slot_next;
    logic       tmo_hit;
    logic       go_hold;
    logic       handshake;

    always_comb begin
        accept    = 1'b0;
        slot_next = slot;
        tmo_hit   = 1'b0;
        go_hold   = 1'b0;
        handshake = BURST_VALID && BURST_READY;
        if (state == FILL) begin
            accept    = WRITE && !FULL;
            slot_next = slot + {2'b00, accept};
            tmo_hit   = (FLUSH_TIMEOUT != 0) && (tmo == TMO_LIMIT);
            // The word of this cycle lands first, so a flush sees the new lane.
            go_hold   = (slot_next == 3'd4) ||
                        ((FLUSH || tmo_hit) && (slot_next != 3'd0));
        end
    end

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
        if (!BUS_RST_N) begin
            state       <= FILL;
            slot        <= 3'd0;
            tmo         <= 8'd0;
            FULL        <= 1'b0;
            BURST_VALID <= 1'b0;
            BURST_DATA  <= '0;
            BURST_MASK  <= 4'd0;
            BURST_ADDR  <= '0;
            LOST_CNT    <= 8'd0;
            BURST_CNT   <= 32'd0;
        end else begin
            if (WRITE && FULL && (LOST_CNT != 8'hFF))
                LOST_CNT <= LOST_CNT + 8'd1;
            case (state)
                FILL: begin
                    if (accept) begin
                        BURST_DATA[{slot[1:0], 5'b00000} +: 32] <= DATA_IN;
                        BURST_MASK[slot[1:0]]                   <= 1'b1;
                        slot                                    <= slot_next;
                    end
                    if (go_hold) begin
                        state       <= HOLD;
                        BURST_VALID <= 1'b1;
                        FULL        <= 1'b1;
                        tmo         <= 8'd0;
                    end else if (accept || (slot_next == 3'd0)) begin
                        tmo <= 8'd0;
                    end else if (tmo != 8'hFF) begin
                        tmo <= tmo + 8'd1;
                    end
                end
                HOLD: begin
                    if (handshake) begin
                        state       <= FILL;
                        BURST_VALID <= 1'b0;
                        FULL        <= 1'b0;
                        slot        <= 3'd0;
                        tmo         <= 8'd0;
                        BURST_DATA  <= '0;
                        BURST_MASK  <= 4'd0;
                        BURST_ADDR  <= BURST_ADDR + 1'b1;
                        BURST_CNT   <= BURST_CNT + 32'd1;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

    assign DBG_STATE = (state == HOLD);

endmodule

// File: tb/tb_ddrvfifo_wr_packer.sv
// Directed bench for ddrvfifo_wr_packer: a table of per-cycle vectors plus
// hand-written sequences for backpressure, timeout, wrap and reset corners.
module tb_ddrvfifo_wr_packer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance a: 4-bit address, timeout disabled.
  logic [31:0]  a_data;
  logic         a_write, a_flush, a_ready;
  logic         a_full, a_valid, a_dbg;
  logic [127:0] a_bdata;
  logic [3:0]   a_mask;
  logic [3:0]   a_addr;
  logic [7:0]   a_lost;
  logic [31:0]  a_cnt;

  // Instance t: default address width, timeout of 8 idle cycles.
  logic [31:0]  t_data;
  logic         t_write, t_flush, t_ready;
  logic         t_full, t_valid, t_dbg;
  logic [127:0] t_bdata;
  logic [3:0]   t_mask;
  logic [23:0]  t_addr;
  logic [7:0]   t_lost;
  logic [31:0]  t_cnt;

  ddrvfifo_wr_packer #(.ADDR_WIDTH(4), .FLUSH_TIMEOUT(0)) dut_a (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .DATA_IN(a_data), .WRITE(a_write),
    .FULL(a_full), .FLUSH(a_flush), .BURST_DATA(a_bdata), .BURST_MASK(a_mask),
    .BURST_ADDR(a_addr), .BURST_VALID(a_valid), .BURST_READY(a_ready),
    .LOST_CNT(a_lost), .BURST_CNT(a_cnt), .DBG_STATE(a_dbg)
  );

  ddrvfifo_wr_packer #(.ADDR_WIDTH(24), .FLUSH_TIMEOUT(8)) dut_t (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .DATA_IN(t_data), .WRITE(t_write),
    .FULL(t_full), .FLUSH(t_flush), .BURST_DATA(t_bdata), .BURST_MASK(t_mask),
    .BURST_ADDR(t_addr), .BURST_VALID(t_valid), .BURST_READY(t_ready),
    .LOST_CNT(t_lost), .BURST_CNT(t_cnt), .DBG_STATE(t_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q[$];

  typedef struct {
    logic         write;
    logic [31:0]  data;
    logic         flush;
    logic         ready;
    logic         exp_valid;
    logic         exp_full;
    logic [3:0]   exp_mask;
    logic [127:0] exp_data;
    logic [3:0]   exp_addr;
    logic [7:0]   exp_lost;
    logic [31:0]  exp_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic w, logic [31:0] d, logic f, logic r,
                              logic v, logic fu, logic [3:0] m, logic [127:0] bd,
                              logic [3:0] ad, logic [7:0] lo, logic [31:0] c);
    vec_t x;
    x.write = w; x.data = d; x.flush = f; x.ready = r;
    x.exp_valid = v; x.exp_full = fu; x.exp_mask = m; x.exp_data = bd;
    x.exp_addr = ad; x.exp_lost = lo; x.exp_cnt = c;
    return x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_a();
    a_write = 1'b0; a_data = 32'd0; a_flush = 1'b0; a_ready = 1'b0;
  endtask

  task automatic idle_t();
    t_write = 1'b0; t_data = 32'd0; t_flush = 1'b0; t_ready = 1'b0;
  endtask

  // Inputs change #1 after a rising edge; outputs are sampled #1 after the next.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_a();
    idle_t();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic write_a(input logic [31:0] d);
    a_write = 1'b1; a_data = d;
    step();
    idle_a();
  endtask

  int n;
  int seen;
  logic [127:0] held;

  initial begin
    idle_a();
    idle_t();
    #2;
    chk("reset_valid_a", a_valid, 1'b0);
    chk("reset_full_a", a_full, 1'b0);
    chk("reset_data_a", a_bdata, 128'd0);
    chk("reset_mask_a", a_mask, 4'd0);
    chk("reset_addr_t", t_addr, 24'd0);
    do_reset();

    // ---------------- table-driven main function ----------------
    vecs[0]  = mk(1, 32'h11, 0, 0, 0, 0, 4'h1, 128'h11, 0, 0, 0);
    vecs[1]  = mk(1, 32'h22, 0, 0, 0, 0, 4'h3, {32'h0, 32'h0, 32'h22, 32'h11}, 0, 0, 0);
    vecs[2]  = mk(1, 32'h33, 0, 0, 0, 0, 4'h7, {32'h0, 32'h33, 32'h22, 32'h11}, 0, 0, 0);
    vecs[3]  = mk(1, 32'h44, 0, 0, 1, 1, 4'hF, {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 0);
    vecs[4]  = mk(0, 32'h0,  0, 1, 0, 0, 4'h0, 128'h0, 1, 0, 1);
    vecs[5]  = mk(1, 32'hA1, 0, 0, 0, 0, 4'h1, 128'hA1, 1, 0, 1);
    vecs[6]  = mk(1, 32'hA2, 1, 0, 1, 1, 4'h3, {32'h0, 32'h0, 32'hA2, 32'hA1}, 1, 0, 1);
    vecs[7]  = mk(1, 32'hFF, 0, 0, 1, 1, 4'h3, {32'h0, 32'h0, 32'hA2, 32'hA1}, 1, 1, 1);
    vecs[8]  = mk(0, 32'h0,  1, 0, 1, 1, 4'h3, {32'h0, 32'h0, 32'hA2, 32'hA1}, 1, 1, 1);
    vecs[9]  = mk(0, 32'h0,  0, 1, 0, 0, 4'h0, 128'h0, 2, 1, 2);
    vecs[10] = mk(0, 32'h0,  1, 0, 0, 0, 4'h0, 128'h0, 2, 1, 2);
    vecs[11] = mk(0, 32'h0,  0, 1, 0, 0, 4'h0, 128'h0, 2, 1, 2);
    vecs[12] = mk(1, 32'h01, 0, 0, 0, 0, 4'h1, 128'h01, 2, 1, 2);
    vecs[13] = mk(1, 32'h02, 0, 0, 0, 0, 4'h3, {32'h0, 32'h0, 32'h02, 32'h01}, 2, 1, 2);
    vecs[14] = mk(1, 32'h03, 0, 0, 0, 0, 4'h7, {32'h0, 32'h03, 32'h02, 32'h01}, 2, 1, 2);
    vecs[15] = mk(1, 32'h04, 1, 0, 1, 1, 4'hF, {32'h04, 32'h03, 32'h02, 32'h01}, 2, 1, 2);
    vecs[16] = mk(1, 32'h55, 0, 1, 0, 0, 4'h0, 128'h0, 3, 2, 3);
    vecs[17] = mk(1, 32'h66, 0, 0, 0, 0, 4'h1, 128'h66, 3, 2, 3);
    vecs[18] = mk(0, 32'h0,  1, 0, 1, 1, 4'h1, 128'h66, 3, 2, 3);
    vecs[19] = mk(0, 32'h0,  0, 1, 0, 0, 4'h0, 128'h0, 4, 2, 4);

    for (int i = 0; i < 20; i++) begin
      a_write = vecs[i].write; a_data = vecs[i].data;
      a_flush = vecs[i].flush; a_ready = vecs[i].ready;
      step();
      chk($sformatf("vec%0d_valid", i), a_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_full", i), a_full, vecs[i].exp_full);
      chk($sformatf("vec%0d_mask", i), a_mask, vecs[i].exp_mask);
      chk($sformatf("vec%0d_data", i), a_bdata, vecs[i].exp_data);
      chk($sformatf("vec%0d_addr", i), a_addr, vecs[i].exp_addr);
      chk($sformatf("vec%0d_lost", i), a_lost, vecs[i].exp_lost);
      chk($sformatf("vec%0d_cnt", i), a_cnt, vecs[i].exp_cnt);
    end
    idle_a();

    // ---------------- backpressure ----------------
    do_reset();
    for (int i = 0; i < 4; i++) write_a(32'h100 + i);
    held = {32'h103, 32'h102, 32'h101, 32'h100};
    for (int i = 0; i < 10; i++) begin
      a_write = 1'b1; a_data = $urandom_range(32'hFFFF, 0); a_ready = 1'b0;
      step();
      chk($sformatf("bp%0d_full", i), a_full, 1'b1);
      chk($sformatf("bp%0d_data", i), a_bdata, held);
    end
    chk("bp_lost", a_lost, 8'd10);
    chk("bp_mask", a_mask, 4'hF);
    chk("bp_addr", a_addr, 4'd0);
    idle_a();
    a_ready = 1'b1;
    step();
    chk("bp_full_release", a_full, 1'b0);
    chk("bp_cnt", a_cnt, 32'd1);
    idle_a();

    // ---------------- lost counter saturation ----------------
    for (int i = 0; i < 4; i++) write_a(32'h200 + i);
    a_write = 1'b1;
    repeat (260) step();
    chk("lost_saturate", a_lost, 8'hFF);

    // ---------------- reset while holding a burst ----------------
    idle_a();
    chk("hold_before_reset", a_valid, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_hold_valid", a_valid, 1'b0);
    chk("rst_hold_full", a_full, 1'b0);
    chk("rst_hold_lost", a_lost, 8'd0);
    chk("rst_hold_cnt", a_cnt, 32'd0);
    chk("rst_hold_addr", a_addr, 4'd0);
    chk("rst_hold_mask", a_mask, 4'd0);
    #1;
    rst_n = 1'b1;
    a_write = 1'b1; a_data = 32'h77;
    step();
    chk("post_reset_mask", a_mask, 4'h1);
    chk("post_reset_data", a_bdata, 128'h77);
    idle_a();

    // ---------------- address wrap, scoreboard on addresses ----------------
    do_reset();
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(4'(i % 16));
      write_a(32'h1000 + i);
      a_flush = 1'b1;
      step();
      idle_a();
      chk($sformatf("wrap%0d_valid", i), a_valid, 1'b1);
      chk($sformatf("wrap%0d_addr", i), a_addr, exp_q.pop_front());
      a_ready = 1'b1;
      step();
      idle_a();
    end
    chk("wrap_cnt", a_cnt, 32'd17);
    chk("wrap_final_addr", a_addr, 4'd1);

    // ---------------- timeout disabled ----------------
    write_a(32'h5A);
    seen = 0;
    repeat (300) begin
      step();
      if (a_valid) seen = 1;
    end
    chk("no_timeout", seen, 0);
    a_flush = 1'b1;
    step();
    idle_a();
    a_ready = 1'b1;
    step();
    idle_a();

    // ---------------- timeout of 8 ----------------
    do_reset();
    t_write = 1'b1; t_data = 32'hABC;
    step();
    idle_t();
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (t_valid) begin
        n = i;
        break;
      end
    end
    chk("timeout_cycle", n, 9);
    chk("timeout_mask", t_mask, 4'h1);
    chk("timeout_data", t_bdata, 128'hABC);
    chk("timeout_addr", t_addr, 24'd0);
    t_ready = 1'b1;
    step();
    idle_t();
    chk("timeout_cnt", t_cnt, 32'd1);
    chk("timeout_addr_next", t_addr, 24'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddrvfifo_wr_packer.md
DDRVFIFO_WR_PACKER -- requirements
Module: ddrvfifo_wr_packer

Interface
REQ-001 Parameter ADDR_WIDTH, default 24: width of the burst address, in 128-bit burst units.
REQ-002 Parameter FLUSH_TIMEOUT, default 255, range 0..255: idle cycles before a partial burst is flushed; 0 disables the timeout.
REQ-003 The block SHALL have one clock, BUS_CLK, and an asynchronous active-low reset, BUS_RST_N.
REQ-004 BUS_CLK  in  1  Single clock; all logic is rising-edge.
REQ-005 BUS_RST_N  in  1  Asynchronous active-low reset.
REQ-006 DATA_IN  in  32  Producer data word.
REQ-007 WRITE  in  1  Producer write strobe; the word is accepted when WRITE=1 and FULL=0.
REQ-008 FULL  out  1  Backpressure to the producer.
REQ-009 FLUSH  in  1  Request to emit the current partial burst.
REQ-010 BURST_DATA  out  128  Packed burst; lane n is bits [32n+31:32n].
REQ-011 BURST_MASK  out  4  Valid-lane mask; bit n marks lane n.
REQ-012 BURST_ADDR  out  ADDR_WIDTH  Target burst address.
REQ-013 BURST_VALID  out  1  Burst offered to the downstream virtual-FIFO core.
REQ-014 BURST_READY  in  1  Downstream accept; the handshake completes when BURST_VALID=1 and BURST_READY=1 at a clock edge.
REQ-015 LOST_CNT  out  8  Count of writes dropped while FULL, saturating.
REQ-016 BURST_CNT  out  32  Count of completed bursts, wrapping.

Function
REQ-017 The FSM SHALL have two states, FILL and HOLD, plus a 3-bit lane counter SLOT (values 0..4).
REQ-018 FILL, accepted WRITE: DATA_IN goes to lane SLOT, mask bit SLOT is set, and SLOT increments.
REQ-019 FILL, accepted WRITE that makes SLOT reach 4: the next state is HOLD.
REQ-020 HOLD outputs: BURST_VALID=1 and FULL=1, registered, starting the cycle after the 4th word is accepted (latency 1 cycle).
REQ-021 HOLD: BURST_DATA, BURST_MASK and BURST_ADDR SHALL be stable until the handshake completes.
REQ-022 FILL: BURST_VALID=0 and FULL=0.
REQ-023 On handshake, the FSM SHALL return to FILL, clear SLOT, MASK and all lanes to 0, and increment BURST_ADDR by 1.
REQ-024 BURST_ADDR SHALL wrap from 2^ADDR_WIDTH-1 to 0.
REQ-025 On handshake, BURST_CNT SHALL increment by 1, wrapping at 2^32.
REQ-026 FULL SHALL deassert the cycle after the handshake; a WRITE in the handshake cycle is not accepted.
REQ-027 Unwritten lanes SHALL read 0.
REQ-028 FLUSH sampled high in FILL with SLOT>0: next state is HOLD with a partial BURST_MASK.
REQ-029 FLUSH with SLOT=0, or FLUSH in HOLD: ignored.
REQ-030 WRITE and FLUSH in the same FILL cycle: the word is accepted first, then the flush applies; the mask includes the new lane.
REQ-031 WRITE and FLUSH in the same cycle that fills lane 3: a normal full burst, mask 4'hF.
REQ-032 Timeout counter: 8-bit, counts cycles in FILL with SLOT>0 and no accepted WRITE; cleared by an accepted WRITE, by entering HOLD, and when SLOT=0.
REQ-033 When the timeout counter equals FLUSH_TIMEOUT (nonzero), the block behaves as FLUSH: HOLD is entered next cycle.
REQ-034 WRITE while FULL=1: the data is dropped and LOST_CNT increments, saturating at 8'hFF.
REQ-035 BURST_READY while BURST_VALID=0: ignored.

Reset
REQ-036 BUS_RST_N low SHALL immediately force FILL, SLOT=0, timeout=0, BURST_VALID=0, FULL=0, BURST_DATA=0, BURST_MASK=0, BURST_ADDR=0, LOST_CNT=0 and BURST_CNT=0.
REQ-037 Reset asserted mid-HOLD SHALL discard the pending burst, with no handshake and no count change.
REQ-038 After BUS_RST_N rises, WRITE SHALL be acceptable from the first clock edge.

Verification
REQ-039 Full burst: 4 consecutive writes 0x11,0x22,0x33,0x44 -> next cycle BURST_VALID=1, BURST_DATA=0x00000044_00000033_00000022_00000011, MASK=4'hF, ADDR=0; READY in the same cycle -> ADDR=1, BURST_CNT=1.
REQ-040 Backpressure: READY held low 10 cycles with WRITE high -> FULL=1 throughout, LOST_CNT=10, burst outputs unchanged; READY=1 -> FULL=0 next cycle.
REQ-041 Partial flush: 2 writes then FLUSH -> MASK=4'h3, lanes 2-3 =0; FLUSH with SLOT=0 -> no BURST_VALID.
REQ-042 Timeout: FLUSH_TIMEOUT=8, 1 write then idle -> BURST_VALID rises on the 9th cycle after the write, MASK=4'h1; FLUSH_TIMEOUT=0 -> never.
REQ-043 Wrap: ADDR_WIDTH=4, 17 bursts -> address sequence 0..15,0; BURST_CNT=17.
REQ-044 Reset mid-HOLD: BUS_RST_N low in HOLD -> BURST_VALID=0 and FULL=0 without a clock; all counters =0.
